west_skew_driver: RTL and testbench

Sequencer for the west edge of the `mac_tile` array. It takes one row-parallel vector per handshake from the L0 side and drives each row's `in_w`/`inst_w` with the per-row diagonal skew the array expects. In WS mode it issues a kernel-load phase (`inst_w[0]`) followed by an execute phase (`inst_w[1]`); in OS mode it issues the execute phase only. It sits between the L0 buffer and the array's west boundary.

---
 rtl/array_pkg.sv | 18 +
 rtl/west_skew_driver_if.sv | 29 ++
 rtl/skew_delay_line.sv | 25 ++
 rtl/west_skew_driver.sv | 121 ++++++++++++
 tb/tb_west_skew_driver.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/array_pkg.sv
// Shared constants and state type for the mac_tile array edge drivers.
package array_pkg;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_DRAIN = 2'd3
  } drv_state_e;

endpackage

// File: rtl/west_skew_driver_if.sv
// Bundle between the L0 side, the west skew driver and the array west boundary.
interface west_skew_driver_if #(
  parameter int bw     = 4,
  parameter int row    = 8,
  parameter int len_bw = 8
);

  logic                start;
  logic                mode;
  logic [len_bw-1:0]   num_act;
  logic [row*bw-1:0]   in_data;
  logic                in_valid;
  logic                in_ready;
  logic [row*bw-1:0]   out_w;
  logic [2*row-1:0]    inst_w;
  logic                busy;
  logic                done;

  modport master (
    output start, mode, num_act, in_data, in_valid,
    input  in_ready, out_w, inst_w, busy, done
  );

  modport slave (
    input  start, mode, num_act, in_data, in_valid,
    output in_ready, out_w, inst_w, busy, done
  );

endinterface

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register; output is the input delayed by depth cycles.
module skew_delay_line #(
  parameter int depth = 1,
  parameter int width = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] d_i,
  output logic [width-1:0] q_o
);

  logic [width-1:0] stage_q [depth];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < depth; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < depth; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[depth-1];

endmodule

// File: rtl/west_skew_driver.sv
// West-edge sequencer: accepts row-parallel vectors and issues them to the array
// with a per-row diagonal skew, running a kernel-load phase before execute in WS mode.
module west_skew_driver
  import array_pkg::*;
#(
  parameter int bw     = 4,
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int len_bw = 8
) (
  input logic               clk,
  input logic               reset,
  west_skew_driver_if.slave bus
);

  localparam int CNT_W = ($clog2(col + 1) > len_bw) ? $clog2(col + 1) : len_bw;

  drv_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [len_bw-1:0] num_act_q, num_act_d;
  logic              done_q, done_d;

  logic              ready;
  logic              accept;
  logic [CNT_W-1:0]  cnt_inc;
  logic [1:0]        slot_inst;

  assign ready        = (state_q == ST_LOAD) || (state_q == ST_EXEC);
  assign accept       = bus.in_valid & ready;
  assign cnt_inc      = cnt_q + CNT_W'(1);
  assign slot_inst    = (state_q == ST_LOAD) ? INST_LOAD : INST_EXEC;

  assign bus.in_ready = ready;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_q;

  // The counter also times DRAIN: the last slot needs row edges to clear row row-1.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    num_act_d = num_act_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          num_act_d = bus.num_act;
          cnt_d     = '0;
          if (bus.mode == MODE_WS)       state_d = ST_LOAD;
          else if (bus.num_act == '0)    state_d = ST_DRAIN;
          else                           state_d = ST_EXEC;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (cnt_inc == CNT_W'(col)) begin
            cnt_d   = '0;
            state_d = (num_act_q == '0) ? ST_DRAIN : ST_EXEC;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_EXEC: begin
        if (accept) begin
          if (cnt_inc == CNT_W'(num_act_q)) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_inc == CNT_W'(row)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      num_act_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      num_act_q <= num_act_d;
      done_q    <= done_d;
    end
  end

  // Row r sees the slot r cycles after row 0; non-accept cycles inject a bubble.
  for (genvar r = 0; r < row; r++) begin : g_row
    logic [bw+1:0] slot;
    logic [bw+1:0] tap;

    assign slot = accept ? {slot_inst, bus.in_data[r*bw +: bw]} : {INST_IDLE, {bw{1'b0}}};

    skew_delay_line #(
      .depth(r + 1),
      .width(bw + 2)
    ) u_delay (
      .clk  (clk),
      .reset(reset),
      .d_i  (slot),
      .q_o  (tap)
    );

    assign bus.out_w[r*bw +: bw] = tap[bw-1:0];
    assign bus.inst_w[2*r +: 2]  = tap[bw+1:bw];
  end

endmodule

// File: tb/tb_west_skew_driver.sv
// Self-checking bench for west_skew_driver against a queue-based pass model.
module tb_west_skew_driver;
  import array_pkg::*;

  localparam int BW  = 4;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int LEN = 8;
  localparam int VW  = ROW * BW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  west_skew_driver_if #(.bw(BW), .row(ROW), .len_bw(LEN)) bus ();

  west_skew_driver #(.bw(BW), .row(ROW), .col(COL), .len_bw(LEN)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: a pass is a queue of pending instructions; every edge issues
  // either the head of the queue (on a handshake) or a bubble, and row r shows
  // whatever was issued r edges earlier.
  typedef struct packed {
    logic [1:0]    inst;
    logic [VW-1:0] data;
  } slot_t;

  slot_t          hist [ROW];
  logic [1:0]     pend [$];
  int             edgeCnt  = 0;
  int             doneEdge = -1;
  bit             mBusy    = 1'b0;
  logic [VW-1:0]  expOut;
  logic [2*ROW-1:0] expInst;
  logic           expReady, expBusy, expDone;

  task automatic advance();
    slot_t s;
    bit    preBusy;
    s       = '0;
    preBusy = mBusy;
    if (reset) begin
      for (int r = 0; r < ROW; r++) hist[r] = '0;
      pend.delete();
      mBusy   = 1'b0;
      expDone = 1'b0;
    end else begin
      if (bus.in_valid && mBusy && pend.size() > 0) begin
        s.inst = pend.pop_front();
        s.data = bus.in_data;
        if (pend.size() == 0) doneEdge = edgeCnt + ROW;
      end
      for (int r = ROW - 1; r > 0; r--) hist[r] = hist[r-1];
      hist[0] = s;
      expDone = preBusy && (edgeCnt == doneEdge);
      if (expDone) mBusy = 1'b0;
      if (bus.start && !preBusy) begin
        if (bus.mode == MODE_WS)
          for (int k = 0; k < COL; k++) pend.push_back(INST_LOAD);
        for (int k = 0; k < int'(bus.num_act); k++) pend.push_back(INST_EXEC);
        mBusy = 1'b1;
        if (pend.size() == 0) doneEdge = edgeCnt + ROW;
      end
    end
    for (int r = 0; r < ROW; r++) begin
      expOut[r*BW +: BW]  = hist[r].data[r*BW +: BW];
      expInst[2*r +: 2]   = hist[r].inst;
    end
    expReady = mBusy && (pend.size() > 0);
    expBusy  = mBusy;
    edgeCnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start    = 1'b0;
    bus.mode     = MODE_WS;
    bus.num_act  = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    advance();
    nChecks++;
    if ({bus.inst_w, bus.out_w, bus.in_ready, bus.busy, bus.done} !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_outputs got inst=%h out=%h rdy=%b busy=%b done=%b want all zero",
               bus.inst_w, bus.out_w, bus.in_ready, bus.busy, bus.done);
    end
    reset = 1'b0;
    advance();
    nChecks++;
    if ({bus.in_ready, bus.busy, bus.done} !== 3'b000) begin
      nFails++;
      $display("[TB] FAIL idle_after_reset got rdy=%b busy=%b done=%b want 000",
               bus.in_ready, bus.busy, bus.done);
    end
  endtask

  task automatic test_ws_basic();
    logic [VW-1:0] vecs [$];
    logic [3:0]    nib;
    int idx = 0, doneN = -1, loads0 = 0, execs0 = 0, loads7 = 0, execs7 = 0, first7 = -1;
    bit rdy;
    for (int k = 0; k < COL; k++) begin
      nib = 4'(k);
      vecs.push_back({ROW{nib}});
    end
    vecs.push_back({ROW{4'hA}});
    vecs.push_back({ROW{4'hB}});
    vecs.push_back({ROW{4'hC}});
    bus.mode = MODE_WS; bus.num_act = 8'd3; bus.start = 1'b1;
    advance();
    bus.start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      nChecks++;
      if ({bus.inst_w, bus.out_w, bus.in_ready, bus.busy, bus.done} !== {expInst, expOut, expReady, expBusy, expDone}) begin
        nFails++;
        $display("[TB] FAIL ws_basic n=%0d got inst=%h out=%h rdy=%b busy=%b done=%b want inst=%h out=%h rdy=%b busy=%b done=%b",
                 n, bus.inst_w, bus.out_w, bus.in_ready, bus.busy, bus.done, expInst, expOut, expReady, expBusy, expDone);
      end
      if (bus.inst_w[1:0] == INST_LOAD) loads0++;
      if (bus.inst_w[1:0] == INST_EXEC) execs0++;
      if (bus.inst_w[2*ROW-1 -: 2] == INST_LOAD) begin
        loads7++;
        if (first7 < 0) first7 = n;
      end
      if (bus.inst_w[2*ROW-1 -: 2] == INST_EXEC) execs7++;
      if (bus.done) begin
        doneN = n;
        break;
      end
      bus.in_valid = (idx < vecs.size());
      bus.in_data  = bus.in_valid ? vecs[idx] : '0;
      rdy = bus.in_ready;
      advance();
      if (bus.in_valid && rdy) idx++;
    end
    bus.in_valid = 1'b0;
    nChecks++;
    if (doneN != 19) begin
      nFails++;
      $display("[TB] FAIL ws_done_time got %0d want %0d", doneN, 19);
    end
    nChecks++;
    if ({loads0, execs0, loads7, execs7} != {32'd8, 32'd3, 32'd8, 32'd3}) begin
      nFails++;
      $display("[TB] FAIL ws_inst_counts got r0=%0d/%0d r7=%0d/%0d want 8/3 8/3", loads0, execs0, loads7, execs7);
    end
    nChecks++;
    if (first7 != 8) begin
      nFails++;
      $display("[TB] FAIL ws_row7_skew got first load n=%0d want 8", first7);
    end
  endtask

  task automatic test_os_exec();
    logic [VW-1:0] vecs [$];
    int idx = 0, doneN = -1, lastE = -100, loadsAny = 0, execs0 = 0;
    bit rdy;
    for (int k = 0; k < 4; k++) vecs.push_back(VW'($urandom));
    bus.mode = MODE_OS; bus.num_act = 8'd4; bus.start = 1'b1;
    advance();
    bus.start = 1'b0; bus.mode = MODE_WS;
    for (int n = 0; n < 60; n++) begin
      nChecks++;
      if ({bus.inst_w, bus.out_w, bus.in_ready, bus.busy, bus.done} !== {expInst, expOut, expReady, expBusy, expDone}) begin
        nFails++;
        $display("[TB] FAIL os_exec n=%0d got inst=%h out=%h rdy=%b busy=%b done=%b want inst=%h out=%h rdy=%b busy=%b done=%b",
                 n, bus.inst_w, bus.out_w, bus.in_ready, bus.busy, bus.done, expInst, expOut, expReady, expBusy, expDone);
      end
      for (int r = 0; r < ROW; r++) if (bus.inst_w[2*r +: 2] == INST_LOAD) loadsAny++;
      if (bus.inst_w[1:0] == INST_EXEC) execs0++;
      if (bus.done) begin
        doneN = n;
        break;
      end
      bus.in_valid = (idx < vecs.size()) && ($urandom_range(3) != 0);
      bus.in_data  = bus.in_valid ? vecs[idx] : '0;
      rdy = bus.in_ready;
      advance();
      if (bus.in_valid && rdy) begin
        idx++;
        lastE = n + 1;
      end
    end
    bus.in_valid = 1'b0;
    nChecks++;
    if (loadsAny != 0 || execs0 != 4) begin
      nFails++;
      $display("[TB] FAIL os_inst_counts got loads=%0d execs=%0d want 0 4", loadsAny, execs0);
    end
    nChecks++;
    if (doneN != lastE + ROW) begin
      nFails++;
      $display("[TB] FAIL os_done_time got %0d want %0d", doneN, lastE + ROW);
    end
  endtask

  task automatic test_ws_bubbles();
    logic [VW-1:0] vecs [$];
    int num, total, idx = 0, doneN = -1, lastE = -1, loads0 = 0, execs0 = 0, bubbles0 = 0, readyDrops = 0;
    bit rdy;
    num   = 2 + $urandom_range(3);
    total = COL + num;
    for (int k = 0; k < total; k++) vecs.push_back(VW'($urandom));
    bus.mode = MODE_WS; bus.num_act = LEN'(num); bus.start = 1'b1;
    advance();
    bus.start = 1'b0;
    for (int n = 0; n < 80; n++) begin
      nChecks++;
      if ({bus.inst_w, bus.out_w, bus.in_ready, bus.busy, bus.done} !== {expInst, expOut, expReady, expBusy, expDone}) begin
        nFails++;
        $display("[TB] FAIL ws_bubbles n=%0d got inst=%h out=%h rdy=%b busy=%b done=%b want inst=%h out=%h rdy=%b busy=%b done=%b",
                 n, bus.inst_w, bus.out_w, bus.in_ready, bus.busy, bus.done, expInst, expOut, expReady, expBusy, expDone);
      end
      if (bus.inst_w[1:0] == INST_LOAD) loads0++;
      if (bus.inst_w[1:0] == INST_EXEC) execs0++;
      if (n >= 1 && n <= 2 * total - 1 && bus.inst_w[1:0] == INST_IDLE && bus.out_w[BW-1:0] == '0) bubbles0++;
      if (idx < total && !bus.in_ready) readyDrops++;
      if (bus.done) begin
        doneN = n;
        break;
      end
      bus.in_valid = (idx < total) && (n % 2 == 0);
      bus.in_data  = bus.in_valid ? vecs[idx] : '0;
      rdy = bus.in_ready;
      advance();
      if (bus.in_valid && rdy) begin
        idx++;
        lastE = n + 1;
      end
    end
    bus.in_valid = 1'b0;
    nChecks++;
    if (loads0 != COL || execs0 != num || bubbles0 != total - 1) begin
      nFails++;
      $display("[TB] FAIL bubble_counts got loads=%0d execs=%0d bubbles=%0d want %0d %0d %0d",
               loads0, execs0, bubbles0, COL, num, total - 1);
    end
    nChecks++;
    if (readyDrops != 0 || doneN != lastE + ROW) begin
      nFails++;
      $display("[TB] FAIL bubble_ready_done got drops=%0d done=%0d want 0 %0d", readyDrops, doneN, lastE + ROW);
    end
  endtask

  task automatic test_start_ignored();
    logic [VW-1:0] vecs [$];
    int idx = 0, doneN = -1, execs0 = 0;
    bit rdy;
    for (int k = 0; k < COL + 5; k++) vecs.push_back(VW'($urandom));
    bus.mode = MODE_WS; bus.num_act = 8'd5; bus.start = 1'b1;
    advance();
    bus.start = 1'b0;
    for (int n = 0; n < 60; n++) begin
      nChecks++;
      if ({bus.inst_w, bus.out_w, bus.in_ready, bus.busy, bus.done} !== {expInst, expOut, expReady, expBusy, expDone}) begin
        nFails++;
        $display("[TB] FAIL start_ignored n=%0d got inst=%h out=%h rdy=%b busy=%b done=%b want inst=%h out=%h rdy=%b busy=%b done=%b",
                 n, bus.inst_w, bus.out_w, bus.in_ready, bus.busy, bus.done, expInst, expOut, expReady, expBusy, expDone);
      end
      if (bus.inst_w[1:0] == INST_EXEC) execs0++;
      if (bus.done) begin
        doneN = n;
        break;
      end
      bus.start    = (n == 10);
      bus.mode     = (n == 10) ? MODE_OS : MODE_WS;
      bus.num_act  = (n == 10) ? 8'd1 : 8'd0;
      bus.in_valid = (idx < vecs.size());
      bus.in_data  = bus.in_valid ? vecs[idx] : '0;
      rdy = bus.in_ready;
      advance();
      if (bus.in_valid && rdy) idx++;
    end
    idle_inputs();
    nChecks++;
    if (execs0 != 5 || doneN != COL + 5 + ROW) begin
      nFails++;
      $display("[TB] FAIL start_ignored_pass got execs=%0d done=%0d want 5 %0d", execs0, doneN, COL + 5 + ROW);
    end
  endtask

  task automatic test_reset_mid_exec();
    logic [VW-1:0] vecs [$];
    int idx = 0, doneN = -1, loads0 = 0, execs0 = 0;
    bit rdy;
    for (int k = 0; k < COL + 6; k++) vecs.push_back(VW'($urandom));
    bus.mode = MODE_WS; bus.num_act = 8'd6; bus.start = 1'b1;
    advance();
    bus.start = 1'b0;
    for (int n = 0; n <= 10; n++) begin
      nChecks++;
      if ({bus.inst_w, bus.out_w, bus.in_ready, bus.busy, bus.done} !== {expInst, expOut, expReady, expBusy, expDone}) begin
        nFails++;
        $display("[TB] FAIL pre_reset n=%0d got inst=%h out=%h rdy=%b busy=%b done=%b want inst=%h out=%h rdy=%b busy=%b done=%b",
                 n, bus.inst_w, bus.out_w, bus.in_ready, bus.busy, bus.done, expInst, expOut, expReady, expBusy, expDone);
      end
      if (n == 10) break;
      bus.in_valid = 1'b1;
      bus.in_data  = vecs[idx];
      rdy = bus.in_ready;
      advance();
      if (rdy) idx++;
    end
    reset = 1'b1;
    advance();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    nChecks++;
    if ({bus.inst_w, bus.out_w, bus.in_ready, bus.busy, bus.done} !== '0) begin
      nFails++;
      $display("[TB] FAIL mid_reset got inst=%h out=%h rdy=%b busy=%b done=%b want all zero",
               bus.inst_w, bus.out_w, bus.in_ready, bus.busy, bus.done);
    end
    vecs.delete();
    idx = 0;
    for (int k = 0; k < COL + 2; k++) vecs.push_back(VW'($urandom));
    bus.mode = MODE_WS; bus.num_act = 8'd2; bus.start = 1'b1;
    advance();
    bus.start = 1'b0;
    for (int n = 0; n < 50; n++) begin
      nChecks++;
      if ({bus.inst_w, bus.out_w, bus.in_ready, bus.busy, bus.done} !== {expInst, expOut, expReady, expBusy, expDone}) begin
        nFails++;
        $display("[TB] FAIL post_reset n=%0d got inst=%h out=%h rdy=%b busy=%b done=%b want inst=%h out=%h rdy=%b busy=%b done=%b",
                 n, bus.inst_w, bus.out_w, bus.in_ready, bus.busy, bus.done, expInst, expOut, expReady, expBusy, expDone);
      end
      if (bus.inst_w[1:0] == INST_LOAD) loads0++;
      if (bus.inst_w[1:0] == INST_EXEC) execs0++;
      if (bus.done) begin
        doneN = n;
        break;
      end
      bus.in_valid = (idx < vecs.size());
      bus.in_data  = bus.in_valid ? vecs[idx] : '0;
      rdy = bus.in_ready;
      advance();
      if (bus.in_valid && rdy) idx++;
    end
    bus.in_valid = 1'b0;
    nChecks++;
    if (loads0 != COL || execs0 != 2 || doneN != COL + 2 + ROW) begin
      nFails++;
      $display("[TB] FAIL fresh_pass got loads=%0d execs=%0d done=%0d want %0d 2 %0d",
               loads0, execs0, doneN, COL, COL + 2 + ROW);
    end
  endtask

  task automatic test_os_zero();
    int doneN = -1, readySeen = 0;
    bus.mode = MODE_OS; bus.num_act = 8'd0; bus.start = 1'b1;
    advance();
    bus.start = 1'b0;
    for (int n = 0; n < 30; n++) begin
      nChecks++;
      if ({bus.inst_w, bus.out_w, bus.in_ready, bus.busy, bus.done} !== {expInst, expOut, expReady, expBusy, expDone}) begin
        nFails++;
        $display("[TB] FAIL os_zero n=%0d got inst=%h out=%h rdy=%b busy=%b done=%b want inst=%h out=%h rdy=%b busy=%b done=%b",
                 n, bus.inst_w, bus.out_w, bus.in_ready, bus.busy, bus.done, expInst, expOut, expReady, expBusy, expDone);
      end
      if (bus.in_ready) readySeen++;
      if (bus.done) begin
        doneN = n;
        break;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = VW'($urandom);
      advance();
    end
    idle_inputs();
    nChecks++;
    if (readySeen != 0 || doneN != ROW) begin
      nFails++;
      $display("[TB] FAIL os_zero_pass got ready_cycles=%0d done=%0d want 0 %0d", readySeen, doneN, ROW);
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] vecs [$];
    int idx = 0, dones = 0, loads0 = 0, execs0 = 0;
    bit rdy;
    for (int k = 0; k < 2 + COL + 1; k++) vecs.push_back(VW'($urandom));
    bus.mode = MODE_OS; bus.num_act = 8'd2; bus.start = 1'b1;
    advance();
    bus.start = 1'b0;
    for (int n = 0; n < 80; n++) begin
      nChecks++;
      if ({bus.inst_w, bus.out_w, bus.in_ready, bus.busy, bus.done} !== {expInst, expOut, expReady, expBusy, expDone}) begin
        nFails++;
        $display("[TB] FAIL back_to_back n=%0d got inst=%h out=%h rdy=%b busy=%b done=%b want inst=%h out=%h rdy=%b busy=%b done=%b",
                 n, bus.inst_w, bus.out_w, bus.in_ready, bus.busy, bus.done, expInst, expOut, expReady, expBusy, expDone);
      end
      if (bus.inst_w[1:0] == INST_LOAD) loads0++;
      if (bus.inst_w[1:0] == INST_EXEC) execs0++;
      if (bus.done) begin
        dones++;
        if (dones == 2) break;
        bus.start = 1'b1; bus.mode = MODE_WS; bus.num_act = 8'd1;
      end
      bus.in_valid = (idx < vecs.size());
      bus.in_data  = bus.in_valid ? vecs[idx] : '0;
      rdy = bus.in_ready;
      advance();
      bus.start = 1'b0;
      if (bus.in_valid && rdy) idx++;
    end
    idle_inputs();
    nChecks++;
    if (dones != 2 || loads0 != COL || execs0 != 3) begin
      nFails++;
      $display("[TB] FAIL back_to_back_pass got dones=%0d loads=%0d execs=%0d want 2 %0d 3", dones, loads0, execs0, COL);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    advance();
    advance();
    test_reset();
    test_ws_basic();
    test_os_exec();
    test_ws_bubbles();
    test_start_ignored();
    test_reset_mid_exec();
    test_os_zero();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
